// File: rtl/fractcam_if.sv
// Handshake bundle for the fractured ternary CAM:
// control-plane write/read ports and the search/result path.
interface fractcam_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) ();
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_keep;
  logic                  wr_entry_valid;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  wr_done;

  logic [ADDR_WIDTH-1:0] rd_cmd_addr;
  logic                  rd_cmd_valid;
  logic                  rd_cmd_ready;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic [DATA_WIDTH-1:0] rd_rsp_keep;
  logic                  rd_rsp_entry_valid;
  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;

  logic [DATA_WIDTH-1:0] search_key;
  logic                  search_valid;
  logic                  search_ready;
  logic [DEPTH-1:0]      match_line;
  logic [ADDR_WIDTH-1:0] match_addr;
  logic                  match_hit;
  logic                  match_valid;
  logic                  match_ready;

  modport master (
    output wr_addr, wr_data, wr_keep, wr_entry_valid, wr_valid,
    input  wr_ready, wr_done,
    output rd_cmd_addr, rd_cmd_valid, rd_rsp_ready,
    input  rd_cmd_ready, rd_rsp_data, rd_rsp_keep,
    input  rd_rsp_entry_valid, rd_rsp_valid,
    output search_key, search_valid, match_ready,
    input  search_ready, match_line, match_addr, match_hit, match_valid
  );

  modport slave (
    input  wr_addr, wr_data, wr_keep, wr_entry_valid, wr_valid,
    output wr_ready, wr_done,
    input  rd_cmd_addr, rd_cmd_valid, rd_rsp_ready,
    output rd_cmd_ready, rd_rsp_data, rd_rsp_keep,
    output rd_rsp_entry_valid, rd_rsp_valid,
    input  search_key, search_valid, match_ready,
    output search_ready, match_line, match_addr, match_hit, match_valid
  );
endinterface

// File: rtl/fractcam_pe.sv
// Fractured TCAM: per-segment match vectors swept over N cycles on
// write/read, with a 2-stage lowest-index priority search pipeline.
module fractcam_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int SEG_BITS   = 5,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  fractcam_if.slave  bus
);
  localparam int N    = 1 << SEG_BITS;
  localparam int SEGS = (DATA_WIDTH + SEG_BITS - 1) / SEG_BITS;
  localparam int PW   = SEGS * SEG_BITS;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  typedef logic [SEG_BITS-1:0] seg_t;

  state_t                state;
  seg_t                  cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PW-1:0]         data_q, keep_q;
  logic [DEPTH-1:0]      valid;
  logic [N-1:0]          vec [SEGS][DEPTH];

  seg_t                  f_q [SEGS];
  seg_t                  a_q [SEGS];
  logic [SEGS-1:0]       fnd_q;
  seg_t                  f_n [SEGS];
  seg_t                  a_n [SEGS];
  logic [SEGS-1:0]       fnd_n;
  logic [PW-1:0]         rdd, rdk;

  logic [PW-1:0]         wd, wk, kp;
  logic [SEGS-1:0]       wbit;
  logic [DEPTH-1:0]      line_n, line_q;
  logic                  s1_v;
  logic [ADDR_WIDTH-1:0] enc;

  logic idle, last, wr_acc, rd_acc, s2_en, s_acc;

  assign idle   = (state == IDLE);
  assign last   = (cnt == '1);
  assign wr_acc = bus.wr_valid && idle;
  assign rd_acc = bus.rd_cmd_valid && bus.rd_cmd_ready;
  assign s2_en  = !bus.match_valid || bus.match_ready;
  assign s_acc  = bus.search_valid && bus.search_ready;

  assign bus.wr_ready     = idle;
  assign bus.rd_cmd_ready = idle && !bus.wr_valid;
  assign bus.search_ready = idle && (!s1_v || s2_en);

  always_comb begin
    wd = '0;
    wk = '0;
    kp = '0;
    wd[DATA_WIDTH-1:0] = bus.wr_data;
    wk[DATA_WIDTH-1:0] = bus.wr_keep;
    kp[DATA_WIDTH-1:0] = bus.search_key;
  end

  always_comb begin
    wbit = '0;
    for (int s = 0; s < SEGS; s++)
      wbit[s] = ((cnt ^ data_q[s*SEG_BITS +: SEG_BITS])
                 & keep_q[s*SEG_BITS +: SEG_BITS]) == '0;
  end

  // Sweep reconstruction: first hit gives the value, later hits
  // knock out the bits that disagree with it (don't-care bits).
  always_comb begin
    fnd_n = fnd_q;
    rdd   = '0;
    rdk   = '0;
    for (int s = 0; s < SEGS; s++) begin
      f_n[s] = f_q[s];
      a_n[s] = a_q[s];
      if (vec[s][addr_q][cnt]) begin
        if (!fnd_q[s]) begin
          f_n[s]   = cnt;
          fnd_n[s] = 1'b1;
        end else begin
          a_n[s] = a_q[s] & ~(cnt ^ f_q[s]);
        end
      end
      rdk[s*SEG_BITS +: SEG_BITS] = fnd_n[s] ? a_n[s] : '1;
      rdd[s*SEG_BITS +: SEG_BITS] = fnd_n[s] ? (f_n[s] & a_n[s]) : '0;
    end
  end

  always_comb begin
    line_n = '0;
    for (int e = 0; e < DEPTH; e++) begin
      line_n[e] = valid[e];
      for (int s = 0; s < SEGS; s++)
        line_n[e] = line_n[e] & vec[s][e][kp[s*SEG_BITS +: SEG_BITS]];
    end
  end

  always_comb begin
    enc = '0;
    for (int e = DEPTH - 1; e >= 0; e--)
      if (line_q[e]) enc = ADDR_WIDTH'(e);
  end

  always_ff @(posedge clk) begin
    if (state == WRITE)
      for (int s = 0; s < SEGS; s++)
        vec[s][addr_q][cnt] <= wbit[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      addr_q                 <= '0;
      data_q                 <= '0;
      keep_q                 <= '0;
      valid                  <= '0;
      fnd_q                  <= '0;
      bus.wr_done            <= 1'b0;
      bus.rd_rsp_data        <= '0;
      bus.rd_rsp_keep        <= '0;
      bus.rd_rsp_entry_valid <= 1'b0;
      bus.rd_rsp_valid       <= 1'b0;
      for (int s = 0; s < SEGS; s++) begin
        f_q[s] <= '0;
        a_q[s] <= '0;
      end
    end else begin
      bus.wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_acc) begin
            addr_q               <= bus.wr_addr;
            data_q               <= wd;
            keep_q               <= wk;
            cnt                  <= '0;
            valid[bus.wr_addr]   <= 1'b0;
            if (bus.wr_entry_valid) state <= WRITE;
            else bus.wr_done <= 1'b1;
          end else if (rd_acc) begin
            addr_q <= bus.rd_cmd_addr;
            cnt    <= '0;
            fnd_q  <= '0;
            state  <= READ;
            for (int s = 0; s < SEGS; s++) a_q[s] <= '1;
          end
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            valid[addr_q] <= 1'b1;
            bus.wr_done   <= 1'b1;
            state         <= IDLE;
          end
        end
        READ: begin
          cnt   <= cnt + 1'b1;
          fnd_q <= fnd_n;
          for (int s = 0; s < SEGS; s++) begin
            f_q[s] <= f_n[s];
            a_q[s] <= a_n[s];
          end
          if (last) begin
            bus.rd_rsp_data        <= rdd[DATA_WIDTH-1:0];
            bus.rd_rsp_keep        <= rdk[DATA_WIDTH-1:0];
            bus.rd_rsp_entry_valid <= valid[addr_q];
            bus.rd_rsp_valid       <= 1'b1;
            state                  <= RESP;
          end
        end
        RESP: begin
          if (bus.rd_rsp_ready) begin
            bus.rd_rsp_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v            <= 1'b0;
      line_q          <= '0;
      bus.match_valid <= 1'b0;
      bus.match_line  <= '0;
      bus.match_addr  <= '0;
      bus.match_hit   <= 1'b0;
    end else begin
      if (s2_en) begin
        bus.match_valid <= s1_v;
        if (s1_v) begin
          bus.match_line <= line_q;
          bus.match_addr <= enc;
          bus.match_hit  <= |line_q;
        end
      end
      if (s_acc) begin
        s1_v   <= 1'b1;
        line_q <= line_n;
      end else if (s2_en) begin
        s1_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fractcam_pe.sv
// Directed bench for fractcam_pe: search table plus write/read,
// backpressure, arbitration, reset-abort and a 6-bit-segment build.
module tb_fractcam_pe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fractcam_if #(.DATA_WIDTH(16), .DEPTH(32)) i ();
  fractcam_pe #(.DATA_WIDTH(16), .DEPTH(32), .SEG_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(i)
  );

  fractcam_if #(.DATA_WIDTH(16), .DEPTH(20)) j ();
  fractcam_pe #(.DATA_WIDTH(16), .DEPTH(20), .SEG_BITS(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(j)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d,
                    input logic [15:0] k, input logic ev,
                    output int lat);
    @(negedge clk);
    i.wr_addr = a; i.wr_data = d; i.wr_keep = k;
    i.wr_entry_valid = ev; i.wr_valid = 1'b1;
    for (int t = 0; t < 100 && !i.wr_ready; t++) @(negedge clk);
    @(negedge clk);
    i.wr_valid = 1'b0;
    lat = 1;
    while (!i.wr_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rd(input logic [4:0] a, output int lat,
                    output logic [15:0] d, output logic [15:0] k,
                    output logic v);
    @(negedge clk);
    i.rd_cmd_addr = a; i.rd_cmd_valid = 1'b1;
    #1;
    for (int t = 0; t < 100 && !i.rd_cmd_ready; t++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    i.rd_cmd_valid = 1'b0;
    lat = 1;
    while (!i.rd_rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    d = i.rd_rsp_data; k = i.rd_rsp_keep; v = i.rd_rsp_entry_valid;
  endtask

  task automatic srch(input logic [15:0] key, output int lat,
                      output logic hit, output logic [4:0] a,
                      output logic [31:0] ln);
    @(negedge clk);
    i.search_key = key; i.search_valid = 1'b1;
    #1;
    for (int t = 0; t < 100 && !i.search_ready; t++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    i.search_valid = 1'b0;
    lat = 1;
    while (!i.match_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hit = i.match_hit; a = i.match_addr; ln = i.match_line;
  endtask

  task automatic srch2(input logic [15:0] key, output int lat,
                       output logic hit, output logic [4:0] a,
                       output logic [19:0] ln);
    @(negedge clk);
    j.search_key = key; j.search_valid = 1'b1;
    #1;
    for (int t = 0; t < 100 && !j.search_ready; t++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    j.search_valid = 1'b0;
    lat = 1;
    while (!j.match_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hit = j.match_hit; a = j.match_addr; ln = j.match_line;
  endtask

  typedef struct {
    logic [15:0] key;
    logic        hit;
    logic [4:0]  addr;
    logic [31:0] line;
  } sv_t;

  sv_t tv [7];

  initial begin
    int lat;
    logic hit, v, ok;
    logic [4:0] a;
    logic [31:0] ln;
    logic [19:0] ln2;
    logic [15:0] d, k;
    logic [15:0] keys [3];
    logic [4:0] got [$];
    int issued, n;
    logic seen;

    tv[0] = '{16'h12F7, 1'b1, 5'd3, 32'h0000_0228};
    tv[1] = '{16'h13F0, 1'b1, 5'd5, 32'h0000_0220};
    tv[2] = '{16'hA5A5, 1'b1, 5'd5, 32'h0000_1220};
    tv[3] = '{16'hA5A4, 1'b1, 5'd5, 32'h0000_0220};
    tv[4] = '{16'h12F0, 1'b1, 5'd3, 32'h0000_0228};
    tv[5] = '{16'h12FF, 1'b1, 5'd3, 32'h0000_0208};
    tv[6] = '{16'hABCD, 1'b1, 5'd9, 32'h0000_0200};

    i.wr_addr = '0; i.wr_data = '0; i.wr_keep = '0;
    i.wr_entry_valid = 1'b0; i.wr_valid = 1'b0;
    i.rd_cmd_addr = '0; i.rd_cmd_valid = 1'b0; i.rd_rsp_ready = 1'b1;
    i.search_key = '0; i.search_valid = 1'b0; i.match_ready = 1'b1;
    j.wr_addr = '0; j.wr_data = '0; j.wr_keep = '0;
    j.wr_entry_valid = 1'b0; j.wr_valid = 1'b0;
    j.rd_cmd_addr = '0; j.rd_cmd_valid = 1'b0; j.rd_rsp_ready = 1'b1;
    j.search_key = '0; j.search_valid = 1'b0; j.match_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst ready", {i.wr_ready, i.rd_cmd_ready, i.search_ready}, 3'b111);
    chk("rst outs", {i.wr_done, i.rd_rsp_valid, i.match_valid,
                     i.match_hit, i.match_addr}, '0);
    chk("rst line", i.match_line, '0);
    rst_n = 1'b1;
    @(negedge clk);

    srch(16'h1234, lat, hit, a, ln);
    chk("empty lat", lat, 2);
    chk("empty hit/addr/line", {hit, a, ln}, '0);

    wr(5'd3, 16'h12F0, 16'hFFF0, 1'b1, lat);
    chk("wr3 lat", lat, 33);
    srch(16'h12F7, lat, hit, a, ln);
    chk("s12F7 hit/addr", {hit, a}, {1'b1, 5'd3});
    srch(16'h13F0, lat, hit, a, ln);
    chk("s13F0 miss", {hit, ln}, '0);

    wr(5'd5, 16'h0000, 16'h0000, 1'b1, lat);
    wr(5'd9, 16'hFFFF, 16'h0000, 1'b1, lat);
    wr(5'd12, 16'hA5A5, 16'hFFFF, 1'b1, lat);
    chk("wr12 lat", lat, 33);
    for (int t = 0; t < 5; t++) begin
      srch(tv[t].key, lat, hit, a, ln);
      chk($sformatf("tv%0d lat", t), lat, 2);
      chk($sformatf("tv%0d res", t), {hit, a, ln},
          {tv[t].hit, tv[t].addr, tv[t].line});
    end

    wr(5'd5, 16'h0000, 16'h0000, 1'b0, lat);
    chk("inval lat", lat, 1);
    for (int t = 5; t < 7; t++) begin
      srch(tv[t].key, lat, hit, a, ln);
      chk($sformatf("tv%0d res", t), {hit, a, ln},
          {tv[t].hit, tv[t].addr, tv[t].line});
    end

    @(negedge clk);
    i.rd_rsp_ready = 1'b0;
    i.rd_cmd_addr = 5'd3; i.rd_cmd_valid = 1'b1;
    #1;
    chk("rd acc", i.rd_cmd_ready, 1'b1);
    @(negedge clk);
    i.rd_cmd_valid = 1'b0;
    lat = 1;
    while (!i.rd_rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("rd3 lat", lat, 33);
    chk("rd3 rsp", {i.rd_rsp_data, i.rd_rsp_keep, i.rd_rsp_entry_valid},
        {16'h12F0, 16'hFFF0, 1'b1});
    ok = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      #1;
      if (!i.rd_rsp_valid || i.rd_cmd_ready ||
          i.rd_rsp_data !== 16'h12F0 || i.rd_rsp_keep !== 16'hFFF0)
        ok = 1'b0;
    end
    chk("rd hold", ok, 1'b1);
    i.rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("rd released", i.rd_rsp_valid, 1'b0);

    rd(5'd12, lat, d, k, v);
    chk("rd12", {d, k, v}, {16'hA5A5, 16'hFFFF, 1'b1});
    rd(5'd5, lat, d, k, v);
    chk("rd5 inval", {d, k, v}, {16'h0000, 16'h0000, 1'b0});

    @(negedge clk);
    i.wr_addr = 5'd7; i.wr_data = 16'h00AA; i.wr_keep = 16'hFFFF;
    i.wr_entry_valid = 1'b1; i.wr_valid = 1'b1;
    i.rd_cmd_addr = 5'd7; i.rd_cmd_valid = 1'b1;
    #1;
    chk("arb", {i.wr_ready, i.rd_cmd_ready}, 2'b10);
    @(negedge clk);
    i.wr_valid = 1'b0;
    n = 1;
    seen = 1'b0;
    ok = 1'b1;
    while (n < 200) begin
      #1;
      if (i.wr_done) seen = 1'b1;
      if (i.rd_cmd_ready) break;
      @(negedge clk);
      n++;
    end
    chk("rd after wr", {seen, 8'(n)}, {1'b1, 8'd33});
    @(negedge clk);
    i.rd_cmd_valid = 1'b0;
    lat = 1;
    while (!i.rd_rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("rd7 lat", lat, 33);
    chk("rd7 rsp", {i.rd_rsp_data, i.rd_rsp_keep, i.rd_rsp_entry_valid},
        {16'h00AA, 16'hFFFF, 1'b1});

    keys[0] = 16'h12F0; keys[1] = 16'h0000; keys[2] = 16'h00AA;
    issued = 0;
    for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
      @(negedge clk);
      i.match_ready = (cyc >= 3);
      i.search_valid = (issued < 3);
      if (issued < 3) i.search_key = keys[issued];
      #1;
      if (cyc == 2) begin
        chk("stall ready", {i.search_ready, 2'(issued)}, {1'b0, 2'd2});
        chk("stall hold", {i.match_valid, i.match_addr}, {1'b1, 5'd3});
      end
      if (i.match_valid && i.match_ready) got.push_back(i.match_addr);
      if (i.search_valid && i.search_ready) issued++;
    end
    i.search_valid = 1'b0;
    i.match_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (i.match_valid) n++;
    end
    chk("stall count", {8'(got.size()), 8'(n)}, {8'd3, 8'd0});
    if (got.size() == 3)
      chk("stall order", {got[0], got[1], got[2]}, {5'd3, 5'd9, 5'd7});

    @(negedge clk);
    j.wr_addr = 5'd17; j.wr_data = 16'hBEEF; j.wr_keep = 16'hFF00;
    j.wr_entry_valid = 1'b1; j.wr_valid = 1'b1;
    #1;
    chk("d2 wr acc", j.wr_ready, 1'b1);
    @(negedge clk);
    j.wr_valid = 1'b0;
    lat = 1;
    while (!j.wr_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("d2 wr lat", lat, 65);
    srch2(16'hBE12, lat, hit, a, ln2);
    chk("d2 hit", {hit, a, ln2}, {1'b1, 5'd17, 20'h20000});
    srch2(16'hBF00, lat, hit, a, ln2);
    chk("d2 miss", {hit, a, ln2}, '0);
    @(negedge clk);
    j.rd_cmd_addr = 5'd17; j.rd_cmd_valid = 1'b1;
    @(negedge clk);
    j.rd_cmd_valid = 1'b0;
    lat = 1;
    while (!j.rd_rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("d2 rd lat", lat, 65);
    chk("d2 rd", {j.rd_rsp_data, j.rd_rsp_keep, j.rd_rsp_entry_valid},
        {16'hBE00, 16'hFF00, 1'b1});

    @(negedge clk);
    i.wr_addr = 5'd11; i.wr_data = 16'h5555; i.wr_keep = 16'hFFFF;
    i.wr_entry_valid = 1'b1; i.wr_valid = 1'b1;
    @(negedge clk);
    i.wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort outs", {i.wr_ready, i.wr_done, i.rd_rsp_valid,
                       i.match_valid, i.match_hit}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (i.wr_done) seen = 1'b1;
    end
    chk("abort no done", seen, 1'b0);
    srch(16'h5555, lat, hit, a, ln);
    chk("abort miss", {hit, a, ln}, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
